sprite_scan_ctrl_module: RTL

// - Sequences the 64x64 monochrome sprite ROM (64-bit row word, 6-bit row address) for the 800x600 VGA path.
// - Prefetches the next line's sprite row during horizontal blanking into a line register.
// - Serialises that line into Red/Green/Blue.
// - Moves the sprite once per frame, bouncing off the screen edges.
// - Sits between sync_module (row/column/ready) and the ROM; runs on the 40 MHz pixel clock.

---
 rtl/sprite_scan_ctrl_pkg.sv | 80 ++++++++
 rtl/sprite_pos_module.sv | 97 +++++++++
 rtl/sprite_scan_ctrl_module.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sprite_scan_ctrl_pkg
// Shared constants, FSM state encoding and small helper functions for the
// 800x600 sprite scan controller (sprite_scan_ctrl_module) and its position
// sub-block (sprite_pos_module).
// ---------------------------------------------------------------------------
package sprite_scan_ctrl_pkg;

    // Screen and sprite geometry
    localparam logic [10:0] H_ACTIVE = 11'd800;
    localparam logic [10:0] V_ACTIVE = 11'd600;
    localparam logic [10:0] SPR      = 11'd64;
    localparam logic [10:0] LAST_ROW = V_ACTIVE - 11'd1;

    // Largest top-left coordinate that keeps the whole sprite on screen
    localparam logic [10:0] X_MAX = H_ACTIVE - SPR;
    localparam logic [10:0] Y_MAX = V_ACTIVE - SPR;

    // Motion
    localparam logic [10:0] INIT_X = 11'd368;
    localparam logic [10:0] INIT_Y = 11'd268;
    localparam logic [10:0] STEP   = 11'd2;

    // ROM read latency is two cycles; the WAIT counter counts down from
    // ROM_LAT-1 to zero so WAIT lasts exactly ROM_LAT cycles.
    localparam logic [1:0] WAIT_INIT = 2'd1;

    // Colours {R,G,B}
    localparam logic [2:0] FG_RGB  = 3'b110;
    localparam logic [2:0] BG_RGB  = 3'b000;
    localparam logic [2:0] OFF_RGB = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UPDATE = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOAD   = 3'd4
    } scan_state_e;

    // One axis of sprite position: coordinate plus direction (1 = increasing)
    typedef struct packed {
        logic [10:0] pos;
        logic        fwd;
    } axis_t;

    // True when base <= p < base + SPR (evaluated in 12 bits so it never wraps)
    function automatic logic in_span(input logic [10:0] p, input logic [10:0] base);
        logic [11:0] p_w;
        logic [11:0] b_w;
        p_w = {1'b0, p};
        b_w = {1'b0, base};
        return (p_w >= b_w) && (p_w < (b_w + {1'b0, SPR}));
    endfunction

    // One bounce step on a single axis; clamps to 0 / max_pos and flips direction
    function automatic axis_t bounce_step(input axis_t a, input logic [10:0] max_pos);
        axis_t       r;
        logic [11:0] sum;
        r   = a;
        sum = {1'b0, a.pos} + {1'b0, STEP};
        if (a.fwd) begin
            if (sum >= {1'b0, max_pos}) begin
                r.pos = max_pos;
                r.fwd = 1'b0;
            end else begin
                r.pos = a.pos + STEP;
            end
        end else begin
            if (a.pos <= STEP) begin
                r.pos = 11'd0;
                r.fwd = 1'b1;
            end else begin
                r.pos = a.pos - STEP;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_pos_module.sv
// ---------------------------------------------------------------------------
// sprite_pos_module
// Holds the sprite's top-left position and applies one bounce step each time
// update_i pulses (once per frame, during vertical blanking).
//
// Configuration macro: SPRITE_MOVE_EN
//   defined   : X/Y bounce off the screen edges by STEP pixels per frame.
//   undefined : position is fixed at INIT_X/INIT_Y, no direction state.
//
// Ports
//   clk       in   pixel clock
//   rst       in   synchronous active-high reset
//   update_i  in   1-cycle pulse: apply one position step
//   x_o       out  sprite left column (11 bits)
//   y_o       out  sprite top row (11 bits)
// ---------------------------------------------------------------------------
module sprite_pos_module
    import sprite_scan_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        update_i,
    output logic [10:0] x_o,
    output logic [10:0] y_o
);

`ifdef SPRITE_MOVE_EN

    axis_t x_q;
    axis_t x_d;
    axis_t y_q;
    axis_t y_d;

    // Next position: one bounce step per update pulse, otherwise hold
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (update_i) begin
            x_d = bounce_step(x_q, X_MAX);
            y_d = bounce_step(y_q, Y_MAX);
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Position and direction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '{pos: INIT_X, fwd: 1'b1};
            y_q <= '{pos: INIT_Y, fwd: 1'b1};
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q.pos;
    assign y_o = y_q.pos;

`else

    logic [10:0] x_q;
    logic [10:0] x_d;
    logic [10:0] y_q;
    logic [10:0] y_d;

    // Static sprite: the update pulse simply re-asserts the home position
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (update_i) begin
            x_d = INIT_X;
            y_d = INIT_Y;
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= INIT_X;
            y_q <= INIT_Y;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

`endif

endmodule

// File: rtl/sprite_scan_ctrl_module.sv
// ---------------------------------------------------------------------------
// sprite_scan_ctrl_module
// Drives a 64x64 monochrome sprite ROM for the 800x600 VGA path. During each
// horizontal blank it prefetches the sprite row for the next line into a line
// register, then serialises that line into R/G/B during active video. Once
// per frame (after the last visible row) the sprite position is stepped.
//
// Configuration macro: SPRITE_MOVE_EN (see sprite_pos_module). Undefined
// builds a static sprite at (INIT_X, INIT_Y).
//
// Ports
//   CLK              in   40 MHz pixel clock
//   RST              in   synchronous active-high reset
//   Ready_Sig        in   1 = active video, Column/Row valid
//   Column_Addr_Sig  in   active column 0..799
//   Row_Addr_Sig     in   active row 0..599
//   Rom_Data         in   sprite row word, bit 63 = leftmost pixel
//   Rom_Addr         out  sprite row address (registered)
//   Red_Sig          out  pixel red   (registered, 1-cycle latency)
//   Green_Sig        out  pixel green (registered, 1-cycle latency)
//   Blue_Sig         out  pixel blue  (registered, 1-cycle latency)
// ---------------------------------------------------------------------------
module sprite_scan_ctrl_module
    import sprite_scan_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        Ready_Sig,
    input  logic [10:0] Column_Addr_Sig,
    input  logic [10:0] Row_Addr_Sig,
    input  logic [63:0] Rom_Data,
    output logic [5:0]  Rom_Addr,
    output logic        Red_Sig,
    output logic        Green_Sig,
    output logic        Blue_Sig
);

    scan_state_e state_q;
    scan_state_e state_d;
    logic        ready_q;
    logic        ready_d;
    logic [10:0] row_q;
    logic [10:0] row_d;
    logic [10:0] next_row_q;
    logic [10:0] next_row_d;
    logic        hit_q;
    logic        hit_d;
    logic [1:0]  wait_cnt_q;
    logic [1:0]  wait_cnt_d;
    logic [5:0]  rom_addr_q;
    logic [5:0]  rom_addr_d;
    logic        line_valid_q;
    logic        line_valid_d;
    logic [63:0] line_reg_q;
    logic [63:0] line_reg_d;
    logic [2:0]  rgb_q;
    logic [2:0]  rgb_d;

    logic        fall_s;
    logic        update_s;
    logic [10:0] x_s;
    logic [10:0] y_s;
    logic [5:0]  pix_off_s;

    sprite_pos_module u_pos (
        .clk      (CLK),
        .rst      (RST),
        .update_i (update_s),
        .x_o      (x_s),
        .y_o      (y_s)
    );

    // End of an active line: Ready was high last cycle and is low now
    assign fall_s   = ready_q & ~Ready_Sig;
    assign update_s = (state_q == ST_UPDATE);

    // Offset into the sprite row; only meaningful when the column is inside
    // the sprite, where the 6-bit difference equals the full difference.
    assign pix_off_s = Column_Addr_Sig[5:0] - x_s[5:0];

    // Line-fetch sequencer next-state logic
    always_comb begin
        state_d      = state_q;
        next_row_d   = next_row_q;
        hit_d        = hit_q;
        wait_cnt_d   = wait_cnt_q;
        rom_addr_d   = rom_addr_q;
        line_valid_d = line_valid_q;
        line_reg_d   = line_reg_q;
        ready_d      = Ready_Sig;
        // Latch the row only while it is valid so the edge sees the ended line
        if (Ready_Sig) begin
            row_d = Row_Addr_Sig;
        end else begin
            row_d = row_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    if (row_q == LAST_ROW) begin
                        next_row_d = 11'd0;
                        state_d    = ST_UPDATE;
                    end else begin
                        next_row_d = row_q + 11'd1;
                        state_d    = ST_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                hit_d = in_span(next_row_q, y_s);
                // Address is left untouched on a miss; LOAD ignores the data
                if (hit_d) begin
                    rom_addr_d = next_row_q[5:0] - y_s[5:0];
                end else begin
                    rom_addr_d = rom_addr_q;
                end
                wait_cnt_d = WAIT_INIT;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            ST_LOAD: begin
                if (hit_q) begin
                    line_reg_d = Rom_Data;
                end else begin
                    line_reg_d = line_reg_q;
                end
                line_valid_d = hit_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pixel colour for the column presented this cycle
    always_comb begin
        rgb_d = OFF_RGB;
        if (!Ready_Sig) begin
            rgb_d = OFF_RGB;
        end else if (line_valid_q && in_span(Column_Addr_Sig, x_s)) begin
            if (line_reg_q[6'd63 - pix_off_s]) begin
                rgb_d = FG_RGB;
            end else begin
                rgb_d = BG_RGB;
            end
        end else begin
            rgb_d = BG_RGB;
        end
    end

    // Sequencer, line buffer and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            row_q        <= 11'd0;
            next_row_q   <= 11'd0;
            hit_q        <= 1'b0;
            wait_cnt_q   <= 2'd0;
            rom_addr_q   <= 6'd0;
            line_valid_q <= 1'b0;
            line_reg_q   <= 64'd0;
            rgb_q        <= 3'b000;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            row_q        <= row_d;
            next_row_q   <= next_row_d;
            hit_q        <= hit_d;
            wait_cnt_q   <= wait_cnt_d;
            rom_addr_q   <= rom_addr_d;
            line_valid_q <= line_valid_d;
            line_reg_q   <= line_reg_d;
            rgb_q        <= rgb_d;
        end
    end

    assign Rom_Addr  = rom_addr_q;
    assign Red_Sig   = rgb_q[2];
    assign Green_Sig = rgb_q[1];
    assign Blue_Sig  = rgb_q[0];

endmodule
